// File: rtl/avs_pkg.sv
// Shared widths and FSM encoding for the serial ADC stream front end.
// No timing of its own; used by adc_stream and its interface.
package avs_pkg;
    localparam int WORD_W = 16;
    localparam int HALF_W = 5;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;
endpackage

// File: rtl/adc_stream_if.sv
// ADC pin bundle plus the parallel sample output of adc_stream.
// Pure wiring, zero latency; there is no backpressure on the sample side.
interface adc_stream_if;
    import avs_pkg::*;

    logic                     enable;
    logic                     sdata;
    logic                     sclk;
    logic                     csn;
    logic signed [WORD_W-1:0] stream;
    logic                     wordValid;
    logic                     overrun;

    modport master (
        input  enable, sdata,
        output sclk, csn, stream, wordValid, overrun
    );

    modport slave (
        output enable, sdata,
        input  sclk, csn, stream, wordValid, overrun
    );
endinterface

// File: rtl/period_timer.sv
// Free-running conversion-start timer; tick is combinational from the count.
// Count is held at zero while enable is low, so re-enabling ticks immediately.
module period_timer #(
    parameter int SAMPLE_PERIOD = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = '0;
        if (enable && (count_q != CNT_LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && (count_q == '0);
endmodule

// File: rtl/adc_stream.sv
// Periodic 16-bit serial ADC reader: tick -> csn low next cycle -> wordValid 1+33*CLKDIV later.
// No backpressure: words are pulsed out once; ticks arriving while busy are dropped with overrun.
module adc_stream
    import avs_pkg::*;
#(
    parameter int CLKDIV        = 4,
    parameter int SAMPLE_PERIOD = 1024
) (
    input  logic          clock,
    input  logic          reset,
    adc_stream_if.master  bus
);
    localparam int DIV_W = $clog2(CLKDIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

    state_t                   state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [HALF_W-1:0]        half_q, half_d;
    logic [WORD_W-1:0]        shreg_q, shreg_d;
    logic signed [WORD_W-1:0] stream_q, stream_d;
    logic                     sclk_q, sclk_d;
    logic                     csn_q, csn_d;
    logic                     wvalid_q, wvalid_d;
    logic                     overrun_q, overrun_d;
    logic                     tick;
    logic                     div_done;

    period_timer #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .tick   (tick)
    );

    assign div_done = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        half_d    = half_q;
        shreg_d   = shreg_q;
        stream_d  = stream_q;
        wvalid_d  = 1'b0;
        overrun_d = tick && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SETUP;
                    div_d   = '0;
                end
            end
            SETUP: begin
                if (div_done) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    half_d  = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                // Even half-periods are sclk low, odd are sclk high.
                if (div_done) begin
                    div_d  = '0;
                    half_d = half_q + 1'b1;
                    if (half_q == HALF_LAST) begin
                        state_d  = HOLD;
                        stream_d = $signed(shreg_q);
                        wvalid_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_done) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered, so they are derived from the next-cycle state.
        sclk_d = (state_d == SHIFT) && half_d[0];
        csn_d  = !((state_q == IDLE && tick) || state_q == SETUP || state_q == SHIFT);

        if (sclk_d && !sclk_q) begin
            shreg_d = {shreg_q[WORD_W-2:0], bus.sdata};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            half_q    <= '0;
            shreg_q   <= '0;
            stream_q  <= '0;
            sclk_q    <= 1'b0;
            csn_q     <= 1'b1;
            wvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            stream_q  <= stream_d;
            sclk_q    <= sclk_d;
            csn_q     <= csn_d;
            wvalid_q  <= wvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.csn       = csn_q;
    assign bus.stream    = stream_q;
    assign bus.wordValid = wvalid_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_adc_stream.sv
// Directed bench for adc_stream: default instance plus a SAMPLE_PERIOD=100 instance for overrun.
// ADC models present MSB on csn fall and each following bit on sclk fall.
module tb_adc_stream;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] adc_word  = 16'h0000;
    logic [15:0] adc_word2 = 16'hC3A5;
    int          bidx  = 0;
    int          bidx2 = 0;

    adc_stream_if bus ();
    adc_stream_if bus2 ();

    adc_stream u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    adc_stream #(.CLKDIV(4), .SAMPLE_PERIOD(100)) u_ovr (
        .clock (clock),
        .reset (reset2),
        .bus   (bus2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        bus.sdata  = 1'b0;
        bus2.sdata = 1'b0;
    end

    always @(negedge bus.csn) begin
        bidx      = 15;
        bus.sdata = adc_word[15];
    end
    always @(negedge bus.sclk) begin
        if (!bus.csn && bidx > 0) begin
            bidx      = bidx - 1;
            bus.sdata = adc_word[bidx];
        end
    end
    always @(negedge bus2.csn) begin
        bidx2      = 15;
        bus2.sdata = adc_word2[15];
    end
    always @(negedge bus2.sclk) begin
        if (!bus2.csn && bidx2 > 0) begin
            bidx2      = bidx2 - 1;
            bus2.sdata = adc_word2[bidx2];
        end
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_wv(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (bus.wordValid) begin
                at = cyc;
                break;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] word;
        int          exp_val;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0, at, wv_cnt, last_wv, sp_err, run, runs, run_err, glitch, val_err, ov_cnt, first_ov;
        logic signed [15:0] prev;

        vecs[0] = '{"a5c3", 16'hA5C3, -23101};
        vecs[1] = '{"8000", 16'h8000, -32768};
        vecs[2] = '{"7fff", 16'h7FFF,  32767};
        vecs[3] = '{"ffff", 16'hFFFF,     -1};
        vecs[4] = '{"0001", 16'h0001,      1};

        bus.enable  = 1'b0;
        bus2.enable = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_csn", bus.csn, 1);
        chk("rst_stream", bus.stream, 0);
        chk("rst_wv", bus.wordValid, 0);
        chk("rst_ovr", bus.overrun, 0);

        // Table: one conversion per vector, tick in first cycle out of reset
        for (int v = 0; v < 5; v++) begin
            reset = 1'b1;
            bus.enable = 1'b0;
            repeat (2) @(negedge clock);
            adc_word   = vecs[v].word;
            bus.enable = 1'b1;
            reset      = 1'b0;
            t0 = cyc;
            @(negedge clock);
            chk({"csn_low_", vecs[v].name}, bus.csn, 0);
            wait_wv(300, at);
            chk({"lat_", vecs[v].name}, at - t0, 133);
            chk({"val_", vecs[v].name}, bus.stream, vecs[v].exp_val);
            @(negedge clock);
            chk({"wv_pulse_", vecs[v].name}, bus.wordValid, 0);
        end

        // Long run: period spacing and csn-low width
        reset = 1'b1;
        bus.enable = 1'b0;
        repeat (2) @(negedge clock);
        adc_word   = 16'hA5C3;
        bus.enable = 1'b1;
        reset      = 1'b0;
        t0 = cyc;
        wv_cnt = 0; last_wv = 0; sp_err = 0; run = 0; runs = 0; run_err = 0; glitch = 0; val_err = 0;
        prev = bus.stream;
        for (int n = 1; n <= 5000; n++) begin
            @(negedge clock);
            if (bus.wordValid) begin
                wv_cnt++;
                if (wv_cnt == 1 && n != 133) sp_err++;
                if (wv_cnt > 1 && (n - last_wv) != 1024) sp_err++;
                if (bus.stream !== 16'hA5C3) val_err++;
                last_wv = n;
            end else if (bus.stream !== prev) begin
                glitch++;
            end
            prev = bus.stream;
            if (bus.csn == 1'b0) begin
                run++;
            end else if (run > 0) begin
                if (run != 133) run_err++;
                runs++;
                run = 0;
            end
        end
        chk("long_wv_count", wv_cnt, 5);
        chk("long_spacing_err", sp_err, 0);
        chk("long_value_err", val_err, 0);
        chk("long_csn_runs", runs, 5);
        chk("long_csn_width_err", run_err, 0);
        chk("long_stream_glitch", glitch, 0);

        // Reset in the middle of SHIFT
        bus.enable = 1'b0;
        repeat (200) @(negedge clock);
        bus.enable = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 65) @(negedge clock);
        chk("mid_csn_before", bus.csn, 0);
        chk("mid_sclk_before", bus.sclk, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_csn", bus.csn, 1);
        chk("abort_sclk", bus.sclk, 0);
        chk("abort_stream", bus.stream, 0);
        chk("abort_wv", bus.wordValid, 0);
        bus.enable = 1'b0;
        reset = 1'b0;
        wv_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (bus.wordValid) wv_cnt++;
        end
        chk("abort_no_wv", wv_cnt, 0);

        // enable dropped mid-SHIFT
        adc_word   = 16'h5A3C;
        bus.enable = 1'b1;
        t0 = cyc;
        repeat (40) @(negedge clock);
        bus.enable = 1'b0;
        wait_wv(300, at);
        chk("endrop_lat", at - t0, 133);
        chk("endrop_val", bus.stream, 16'sh5A3C);
        wv_cnt = 0; run = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (bus.wordValid) wv_cnt++;
            if (!bus.csn) run++;
        end
        chk("endrop_no_wv", wv_cnt, 0);
        chk("endrop_csn_high", run, 0);

        // Overrun with SAMPLE_PERIOD=100: every second tick dropped
        bus2.enable = 1'b1;
        reset2 = 1'b0;
        t0 = cyc;
        wv_cnt = 0; ov_cnt = 0; first_ov = -1; sp_err = 0; val_err = 0; last_wv = 0;
        for (int n = 1; n < 1000; n++) begin
            @(negedge clock);
            if (bus2.overrun) begin
                ov_cnt++;
                if (first_ov < 0) first_ov = n;
            end
            if (bus2.wordValid) begin
                wv_cnt++;
                if (wv_cnt == 1 && n != 133) sp_err++;
                if (wv_cnt > 1 && (n - last_wv) != 200) sp_err++;
                if (bus2.stream !== 16'hC3A5) val_err++;
                last_wv = n;
            end
        end
        chk("ovr_count", ov_cnt, 5);
        chk("ovr_first", first_ov, 101);
        chk("ovr_wv_count", wv_cnt, 5);
        chk("ovr_wv_spacing_err", sp_err, 0);
        chk("ovr_value_err", val_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
